// File: rtl/pdm_in_arbiter_if.sv
// Requester-side bundle of pdm_in_arbiter: request, length, FWFT data, pop,
// done and resp_err. The sources drive the master side, the arbiter the slave.
//   req      : per-source request, held until that source's done pulse
//   req_len  : per-source packet length, LEN_W bits per source
//   req_data : per-source FWFT queue head, DATA_W bits per source
//   req_pop  : one-hot pop back to the granted source
//   done     : one-cycle completion pulse to the granted source
//   resp_err : valid with done, 1 = packet dropped or aborted
interface pdm_in_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int LEN_W   = 6
) ();
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*LEN_W-1:0]  req_len;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_pop;
   logic [NUM_REQ-1:0]        done;
   logic                      resp_err;

   modport master (
      output req, req_len, req_data,
      input  req_pop, done, resp_err
   );

   modport slave (
      input  req, req_len, req_data,
      output req_pop, done, resp_err
   );
endinterface

// File: rtl/pdm_in_arbiter.sv
// Round-robin arbiter/sequencer sharing the PDM core input port
// (data_in / bnd_plse / ack) between NUM_REQ packet sources.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   host       : requester bundle (pdm_in_arbiter_if.slave)
//   data_in    : registered byte to the core
//   bnd_plse   : registered start-of-packet pulse, with the first byte
//   ack        : core packet-accept strobe, sampled in WAIT_ACK only
//   gnt        : index of the current/last grant
//   busy       : high in any state except IDLE
//   err_len    : sticky, illegal length seen
//   err_tmo    : sticky, ack timeout seen
// Build option: define PDM_ARB_TIMEOUT_EN to abort a packet after
// ACK_TIMEOUT WAIT_ACK cycles without ack; otherwise err_tmo is tied 0.
module pdm_in_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int MAX_LEN     = 32,
   parameter int ACK_TIMEOUT = 64,
   localparam int LEN_W      = $clog2(MAX_LEN + 1),
   localparam int GW         = $clog2(NUM_REQ)
) (
   input  logic              clk,
   input  logic              reset,
   pdm_in_arbiter_if.slave   host,
   output logic [DATA_W-1:0] data_in,
   output logic              bnd_plse,
   input  logic              ack,
   output logic [GW-1:0]     gnt,
   output logic              busy,
   output logic              err_len,
   output logic              err_tmo
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_ACK,
      DROP
   } state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       ptr_q, ptr_d;
   logic [GW-1:0]       gnt_d;
   logic [GW-1:0]       sel;
   logic                found;
   int                  idx;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   data_d;
   logic                bnd_d;
   logic                set_len;
   logic                tmo_hit;
   logic [NUM_REQ-1:0]  pop_v;
   logic [NUM_REQ-1:0]  done_v;
   logic                rerr_v;

   logic [DATA_W-1:0]   data_a [NUM_REQ];
   logic [LEN_W-1:0]    len_a  [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign data_a[i] = host.req_data[i*DATA_W +: DATA_W];
      assign len_a[i]  = host.req_len[i*LEN_W +: LEN_W];
   end

   function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] g);
      return (g == GW'(NUM_REQ - 1)) ? '0 : g + 1'b1;
   endfunction

   // First requester at or above the pointer, wrapping around.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(ptr_q) + i) % NUM_REQ;
         if (!found && host.req[GW'(idx)]) begin
            found = 1'b1;
            sel   = GW'(idx);
         end
      end
   end

`ifdef PDM_ARB_TIMEOUT_EN
   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_tmo_q;

   // Zero outside WAIT_ACK, so it starts clean on every entry.
   always_comb begin
      tmo_d = '0;
      if (state_q == WAIT_ACK)
         tmo_d = tmo_q + TW'(!ack);
   end

   // Last allowed cycle; an ack in this same cycle still wins.
   assign tmo_hit = (state_q == WAIT_ACK) && !ack &&
                    (tmo_q == TW'(ACK_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_q     <= '0;
         err_tmo_q <= 1'b0;
      end else begin
         tmo_q     <= tmo_d;
         err_tmo_q <= err_tmo_q | tmo_hit;
      end
   end

   assign err_tmo = err_tmo_q;
`else
   assign tmo_hit = 1'b0;
   assign err_tmo = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt;
      len_d   = len_q;
      cnt_d   = cnt_q;
      data_d  = '0;
      bnd_d   = 1'b0;
      set_len = 1'b0;
      pop_v   = '0;
      done_v  = '0;
      rerr_v  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d = sel;
               len_d = len_a[sel];
               cnt_d = '0;
               if (len_a[sel] == '0 ||
                   len_a[sel] > LEN_W'(MAX_LEN))
                  state_d = DROP;
               else
                  state_d = SEND;
            end
         end
         SEND: begin
            pop_v[gnt] = 1'b1;
            data_d     = data_a[gnt];
            bnd_d      = (cnt_q == '0);
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == len_q - 1'b1)
               state_d = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (ack || tmo_hit) begin
               done_v[gnt] = 1'b1;
               rerr_v      = !ack;
               ptr_d       = wrap_inc(gnt);
               state_d     = IDLE;
            end
         end
         DROP: begin
            done_v[gnt] = 1'b1;
            rerr_v      = 1'b1;
            set_len     = 1'b1;
            ptr_d       = wrap_inc(gnt);
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         gnt      <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         data_in  <= '0;
         bnd_plse <= 1'b0;
         err_len  <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         gnt      <= gnt_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         data_in  <= data_d;
         bnd_plse <= bnd_d;
         err_len  <= err_len | set_len;
      end
   end

   // Reset aborts at once: no pop or done escapes in the reset cycle.
   assign host.req_pop  = reset ? '0 : pop_v;
   assign host.done     = reset ? '0 : done_v;
   assign host.resp_err = !reset && rerr_v;
   assign busy          = (state_q != IDLE);

endmodule
